// File: rtl/i2c_target.sv
// I2C target (7-bit addressing, no clock stretching): filtered SCL/SDA sampling,
// address match, write reception and read transmission with per-byte ACK/NACK.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       selected,
    output logic       bus_stop
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE
    } state_t;

    state_t              state, state_n;
    logic                scl_p0, scl_p1, sda_p0, sda_p1;
    logic [FILT_LEN-1:0] scl_hist, sda_hist;
    logic                scl_f, sda_f, scl_f_d, sda_f_d;
    logic                scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]          bit_cnt, bit_cnt_n;
    logic [7:0]          sr, sr_n, sr_in, tx_sr, tx_sr_n;
    logic                sda_oe, sda_oe_n;
    logic                selected_n, first, first_n, rw, rw_n, phase, phase_n;
    logic [7:0]          rx_data_n;
    logic                rx_valid_n, rx_first_n, tx_req_n, bus_stop_n, tx_req_d;

    // Level only moves once every sample in the history agrees.
    function automatic logic filt(input logic [FILT_LEN-1:0] h, input logic cur);
        if (&h)
            return 1'b1;
        else if (~|h)
            return 1'b0;
        else
            return cur;
    endfunction

    function automatic logic addr_match(input logic [7:0] b);
        return b[7:1] == TARGET_ADDR;
    endfunction

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_p0   <= 1'b1;
            scl_p1   <= 1'b1;
            sda_p0   <= 1'b1;
            sda_p1   <= 1'b1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_f_d  <= 1'b1;
            sda_f_d  <= 1'b1;
        end else begin
            scl_p0   <= scl;
            scl_p1   <= scl_p0;
            sda_p0   <= sda;
            sda_p1   <= sda_p0;
            scl_hist <= {scl_hist[FILT_LEN-2:0], scl_p1};
            sda_hist <= {sda_hist[FILT_LEN-2:0], sda_p1};
            scl_f    <= filt(scl_hist, scl_f);
            sda_f    <= filt(sda_hist, sda_f);
            scl_f_d  <= scl_f;
            sda_f_d  <= sda_f;
        end
    end

    assign scl_rise  = scl_f & ~scl_f_d;
    assign scl_fall  = ~scl_f & scl_f_d;
    assign start_det = scl_f & scl_f_d & sda_f_d & ~sda_f;
    assign stop_det  = scl_f & scl_f_d & ~sda_f_d & sda_f;
    assign sr_in     = {sr[6:0], sda_f};

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        sr_n       = sr;
        tx_sr_n    = tx_req_d ? tx_data : tx_sr;
        sda_oe_n   = sda_oe;
        selected_n = selected;
        first_n    = first;
        rw_n       = rw;
        phase_n    = phase;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        rx_first_n = rx_first;
        tx_req_n   = 1'b0;
        bus_stop_n = 1'b0;
        if (stop_det) begin
            state_n    = IDLE;
            sda_oe_n   = 1'b0;
            selected_n = 1'b0;
            bus_stop_n = 1'b1;
        end else if (start_det) begin
            state_n    = ADDR;
            bit_cnt_n  = 3'd0;
            sda_oe_n   = 1'b0;
            selected_n = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    sr_n      = sr_in;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (addr_match(sr_in)) begin
                            state_n    = ADDR_ACK;
                            rw_n       = sr_in[0];
                            selected_n = 1'b1;
                            first_n    = 1'b1;
                            tx_req_n   = sr_in[0];
                            phase_n    = 1'b0;
                        end else begin
                            state_n = IGNORE;
                        end
                    end
                end
                // phase 0: first SCL fall starts the ACK; phase 1: next fall ends it
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_oe_n = 1'b1;
                        phase_n  = 1'b1;
                    end else begin
                        bit_cnt_n = 3'd0;
                        if (state == ADDR_ACK && rw) begin
                            state_n  = READ;
                            sda_oe_n = ~tx_sr[7];
                        end else begin
                            state_n  = WRITE;
                            sda_oe_n = 1'b0;
                        end
                    end
                end
                WRITE: if (scl_rise) begin
                    sr_n      = sr_in;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_n  = sr_in;
                        rx_valid_n = 1'b1;
                        rx_first_n = first;
                        first_n    = 1'b0;
                        state_n    = WR_ACK;
                        phase_n    = 1'b0;
                    end
                end
                READ: if (scl_fall) begin
                    if (bit_cnt == 3'd7) begin
                        sda_oe_n = 1'b0;
                        state_n  = RD_ACK;
                        phase_n  = 1'b0;
                    end else begin
                        sda_oe_n  = ~tx_sr[6];
                        tx_sr_n   = {tx_sr[6:0], 1'b0};
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
                // Next byte is requested only when the controller ACKs.
                RD_ACK: if (scl_rise && !phase) begin
                    if (sda_f) begin
                        state_n    = IGNORE;
                        selected_n = 1'b0;
                    end else begin
                        tx_req_n = 1'b1;
                        phase_n  = 1'b1;
                    end
                end else if (scl_fall && phase) begin
                    state_n   = READ;
                    bit_cnt_n = 3'd0;
                    sda_oe_n  = ~tx_sr[7];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            sda_oe   <= 1'b0;
            selected <= 1'b0;
            first    <= 1'b0;
            rw       <= 1'b0;
            phase    <= 1'b0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            tx_req   <= 1'b0;
            tx_req_d <= 1'b0;
            bus_stop <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            sda_oe   <= sda_oe_n;
            selected <= selected_n;
            first    <= first_n;
            rw       <= rw_n;
            phase    <= phase_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            rx_first <= rx_first_n;
            tx_req   <= tx_req_n;
            tx_req_d <= tx_req;
            bus_stop <= bus_stop_n;
        end
    end

    always_ff @(posedge clk) begin
        sr    <= sr_n;
        tx_sr <= tx_sr_n;
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bus-level bench for i2c_target: a bit-banged controller, a transaction-level
// reference model, and scoreboard monitors for rx_valid, tx_req and bus_stop.
module tb_i2c_target;
    localparam logic [6:0] TADDR = 7'h50;
    localparam int         Q     = 8;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl     = 1'b1;
    logic       ctl_low = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, tx_req, selected, bus_stop;

    pullup (sda);
    assign sda = ctl_low ? 1'b0 : 1'bz;

    i2c_target #(.TARGET_ADDR(TADDR), .FILT_LEN(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .scl      (scl),
        .sda      (sda),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_first (rx_first),
        .tx_req   (tx_req),
        .tx_data  (tx_data),
        .selected (selected),
        .bus_stop (bus_stop)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] rx_q[$];
    logic [7:0] tx_q[$];
    int         stop_pend = 0;
    bit         glitch_en = 1'b0;
    logic [7:0] wbuf[0:3];
    logic [7:0] rbuf[0:3];
    logic [8:0] rx_exp;
    logic [7:0] tx_next;
    logic       sda_prev = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (reset_n && rx_valid) begin
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL rx_valid_unexpected: got data 0x%0h, expected no pulse", rx_data);
            end else begin
                rx_exp = rx_q.pop_front();
                if ({rx_first, rx_data} != rx_exp) begin
                    errors++;
                    $display("FAIL rx_byte: got first=%0b data=0x%0h, expected first=%0b data=0x%0h",
                             rx_first, rx_data, rx_exp[8], rx_exp[7:0]);
                end
            end
        end
        if (reset_n && bus_stop) begin
            checks++;
            if (stop_pend == 0) begin
                errors++;
                $display("FAIL bus_stop_unexpected: got pulse, expected none");
            end else begin
                stop_pend--;
            end
        end
        if (reset_n && scl && sda_prev && !sda && !ctl_low) begin
            checks++;
            errors++;
            $display("FAIL sda_fall_while_scl_high: got sda driven low, expected no change at %0t", $time);
        end
        sda_prev = sda;
    end

    // Read-data supplier: byte made valid for the sampling edge two clk after tx_req.
    initial forever begin
        @(negedge clk);
        if (reset_n && tx_req) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_req_unexpected: got pulse, expected none at %0t", $time);
            end else begin
                tx_next = tx_q.pop_front();
                @(negedge clk);
                tx_data = tx_next;
                @(negedge clk);
                tx_data = 8'($urandom);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic glitch_sda();
        ctl_low = ~ctl_low;
        wclk(1);
        ctl_low = ~ctl_low;
    endtask

    task automatic glitch_scl();
        scl = ~scl;
        wclk(1);
        scl = ~scl;
    endtask

    task automatic bus_start();
        if (!scl) begin
            ctl_low = 1'b0;
            wclk(Q);
            scl = 1'b1;
            wclk(Q);
        end
        ctl_low = 1'b1;
        wclk(Q);
        scl = 1'b0;
        wclk(Q);
    endtask

    task automatic bus_stop_seq();
        stop_pend++;
        ctl_low = 1'b1;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        ctl_low = 1'b0;
        wclk(2 * Q);
        check("stop_seen", stop_pend, 0);
        check("selected_after_stop", int'(selected), 0);
    endtask

    task automatic send_bit(input logic b);
        ctl_low = ~b;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        if (glitch_en) begin glitch_sda(); wclk(Q - 1); end
        else wclk(Q);
        scl = 1'b0;
        if (glitch_en) begin wclk(Q / 2); glitch_scl(); wclk(Q / 2 - 1); end
        else wclk(Q);
    endtask

    task automatic read_bit(output logic b);
        ctl_low = 1'b0;
        wclk(Q);
        scl = 1'b1;
        wclk(Q);
        b = sda;
        wclk(Q);
        scl = 1'b0;
        wclk(Q);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] v, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        send_bit(nack);
    endtask

    // Reference: a target answers iff address bits match; writes are ACKed and
    // reported with first-flag on byte 0; reads return the supplied bytes in order.
    task automatic do_write(input logic [7:0] a, input int n);
        logic ack;
        bit   hit;
        hit = (a[7:1] == TADDR);
        bus_start();
        send_byte(a, ack);
        check("addr_ack_wr", int'(ack), hit ? 0 : 1);
        check("selected_wr_addr", int'(selected), hit ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            if (hit) rx_q.push_back({(i == 0), wbuf[i]});
            send_byte(wbuf[i], ack);
            check("wr_ack", int'(ack), hit ? 0 : 1);
        end
        check("selected_wr_end", int'(selected), hit ? 1 : 0);
        check("rx_pending", rx_q.size(), 0);
    endtask

    task automatic do_read(input logic [7:0] a, input int n);
        logic       ack;
        logic [7:0] v;
        bit         hit;
        hit = (a[7:1] == TADDR);
        if (hit) for (int i = 0; i < n; i++) tx_q.push_back(rbuf[i]);
        bus_start();
        send_byte(a, ack);
        check("addr_ack_rd", int'(ack), hit ? 0 : 1);
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(v, (i == n - 1));
                check("rd_byte", int'(v), int'(rbuf[i]));
                if (i < n - 1) check("selected_rd", int'(selected), 1);
            end
            check("selected_after_nack", int'(selected), 0);
        end
        check("tx_pending", tx_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda"}, int'(sda), 1);
        check({tag, "_rx_data"}, int'(rx_data), 0);
        check({tag, "_rx_valid"}, int'(rx_valid), 0);
        check({tag, "_rx_first"}, int'(rx_first), 0);
        check({tag, "_tx_req"}, int'(tx_req), 0);
        check({tag, "_selected"}, int'(selected), 0);
        check({tag, "_bus_stop"}, int'(bus_stop), 0);
    endtask

    initial begin
        logic [7:0] a;
        logic       ack, b;
        int         n;

        wclk(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        wclk(10);

        // write 0x12, 0x34
        wbuf[0] = 8'h12; wbuf[1] = 8'h34;
        do_write(8'hA0, 2);
        bus_stop_seq();

        // read 0xC5 (ACK), 0x3A (NACK)
        rbuf[0] = 8'hC5; rbuf[1] = 8'h3A;
        do_read(8'hA1, 2);
        bus_stop_seq();

        // foreign address and general call
        wbuf[0] = 8'h55;
        do_write(8'hA4, 1);
        bus_stop_seq();
        do_write(8'h00, 1);
        bus_stop_seq();

        // write, repeated START, read
        wbuf[0] = 8'h01;
        do_write(8'hA0, 1);
        rbuf[0] = 8'($urandom);
        do_read(8'hA1, 1);
        bus_stop_seq();

        // single-clk glitches on both lines
        glitch_en = 1'b1;
        glitch_sda();
        wclk(Q);
        glitch_scl();
        wclk(Q);
        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        do_write(8'hA0, 2);
        rbuf[0] = 8'($urandom); rbuf[1] = 8'($urandom);
        do_read(8'hA1, 2);
        bus_stop_seq();
        glitch_en = 1'b0;

        // reset during bit 4 of a read byte
        wbuf[0] = 8'h5A;
        do_write(8'hA0, 1);
        bus_stop_seq();
        tx_q.push_back(8'h00);
        bus_start();
        send_byte(8'hA1, ack);
        check("rst_addr_ack", int'(ack), 0);
        for (int i = 0; i < 3; i++) begin
            read_bit(b);
            check("rst_rd_bit", int'(b), 0);
        end
        ctl_low = 1'b0;
        wclk(Q);
        scl = 1'b1;
        wclk(Q / 2);
        check("rst_bit4_driven", int'(sda), 0);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        wclk(4);
        reset_n = 1'b1;
        wclk(Q);
        scl = 1'b0;
        wclk(Q);
        check("tx_after_reset", tx_q.size(), 0);
        wbuf[0] = 8'($urandom);
        do_write(8'hA0, 1);
        rbuf[0] = 8'($urandom);
        do_read(8'hA1, 1);
        bus_stop_seq();

        // randomized transactions, mixed STOP / repeated START
        for (int t = 0; t < 20; t++) begin
            a[7:1] = ($urandom_range(0, 1) == 1) ? TADDR : 7'($urandom);
            a[0]   = 1'($urandom_range(0, 1));
            n      = $urandom_range(1, 3);
            if (a[0]) begin
                for (int i = 0; i < n; i++) rbuf[i] = 8'($urandom);
                do_read(a, n);
            end else begin
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                do_write(a, n);
            end
            if ($urandom_range(0, 1) == 1) bus_stop_seq();
        end
        if (!scl) bus_stop_seq();

        wclk(20);
        check("rx_q_empty", rx_q.size(), 0);
        check("tx_q_empty", tx_q.size(), 0);
        check("stop_pend_zero", stop_pend, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
